// File: rtl/trackball_quad_emulator.sv
// Trackball quadrature emulator: turns signed relative motion deltas into
// per-axis direction + count-clock pulse trains for the LETA counter inputs.

module trackball_quad_axis #(
    parameter int STEP_DIV = 64,
    parameter int ACC_W    = 12,
    parameter int DELTA_W  = 9
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic [DELTA_W-1:0] delta,
    input  logic               delta_stb,
    output logic               dir,
    output logic               pclk,
    output logic               busy
);

    localparam int CNT_W = 10;
    localparam int SUM_W = ((ACC_W > DELTA_W) ? ACC_W : DELTA_W) + 2;

    localparam logic [CNT_W-1:0]        LAST     = CNT_W'(STEP_DIV - 1);
    localparam logic signed [SUM_W-1:0] ONE      = SUM_W'(1);
    localparam logic signed [SUM_W-1:0] SAT_MAX  = SUM_W'((2 ** (ACC_W - 1)) - 1);
    localparam logic signed [SUM_W-1:0] SAT_MIN  = -SAT_MAX;
    localparam logic signed [ACC_W-1:0] PEND_MAX = ACC_W'((2 ** (ACC_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] PEND_MIN = -PEND_MAX;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        HIGH  = 2'd2,
        LOW   = 2'd3
    } state_t;

    state_t                    state, state_next;
    logic [CNT_W-1:0]          cnt, cnt_next;
    logic signed [ACC_W-1:0]   pend, pend_next;
    logic                      dir_q, dir_next;
    logic                      busy_q, busy_next;
    logic                      consume;
    logic                      phase_done;
    logic                      pend_nz;
    logic                      pend_pos;

    logic signed [SUM_W-1:0]   pend_ext;
    logic signed [SUM_W-1:0]   delta_ext;
    logic signed [SUM_W-1:0]   sum;

    assign phase_done = (cnt == LAST);
    assign pend_nz    = (pend != '0);
    assign pend_pos   = pend_nz && !pend[ACC_W-1];

    // State register
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of its neighbours.
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            pend   <= '0;
            dir_q  <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            state  <= state_next;
            cnt    <= cnt_next;
            pend   <= pend_next;
            dir_q  <= dir_next;
            busy_q <= busy_next;
        end
    end

    // Next-state logic: phase sequencing and count consumption
    always_comb begin
        // NOTE: every output of this block gets a default first, otherwise
        // the paths that do not assign it would infer a latch.
        state_next = state;
        cnt_next   = cnt;
        dir_next   = dir_q;
        consume    = 1'b0;

        if (!enable) begin
            state_next = IDLE;
            cnt_next   = '0;
        end else begin
            case (state)
                IDLE: begin
                    cnt_next = '0;
                    if (pend_nz) begin
                        state_next = SETUP;
                        dir_next   = pend_pos;
                    end
                end
                SETUP: begin
                    if (phase_done) begin
                        state_next = HIGH;
                        cnt_next   = '0;
                        consume    = 1'b1;
                    end else begin
                        cnt_next = cnt + CNT_W'(1);
                    end
                end
                HIGH: begin
                    if (phase_done) begin
                        state_next = LOW;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt + CNT_W'(1);
                    end
                end
                LOW: begin
                    if (phase_done) begin
                        cnt_next = '0;
                        if (!pend_nz) begin
                            state_next = IDLE;
                        end else if (pend_pos == dir_q) begin
                            state_next = HIGH;
                            consume    = 1'b1;
                        end else begin
                            // Reversal: re-run setup so dir settles before the next rise
                            state_next = SETUP;
                            dir_next   = pend_pos;
                        end
                    end else begin
                        cnt_next = cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end
            endcase
        end
    end

    // Pending-count accumulator with symmetric saturation
    always_comb begin
        pend_ext  = {{(SUM_W - ACC_W){pend[ACC_W-1]}}, pend};
        delta_ext = '0;
        if (delta_stb) begin
            delta_ext = {{(SUM_W - DELTA_W){delta[DELTA_W-1]}}, delta};
        end

        sum = pend_ext + delta_ext;
        if (consume) begin
            sum = dir_q ? (sum - ONE) : (sum + ONE);
        end

        if (!enable) begin
            pend_next = '0;
        end else if (sum > SAT_MAX) begin
            pend_next = PEND_MAX;
        end else if (sum < SAT_MIN) begin
            pend_next = PEND_MIN;
        end else begin
            pend_next = sum[ACC_W-1:0];
        end

        busy_next = (state_next != IDLE) || (pend_next != '0);
    end

    // Output logic
    always_comb begin
        pclk = (state == HIGH);
        dir  = dir_q;
        busy = busy_q;
    end

endmodule

module trackball_quad_emulator #(
    parameter int STEP_DIV = 64,
    parameter int ACC_W    = 12,
    parameter int DELTA_W  = 9
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic [DELTA_W-1:0] delta_x,
    input  logic [DELTA_W-1:0] delta_y,
    input  logic               delta_stb,
    output logic               hdir,
    output logic               hclk,
    output logic               vdir,
    output logic               vclk,
    output logic               busy
);

    logic busy_x;
    logic busy_y;

    trackball_quad_axis #(
        .STEP_DIV (STEP_DIV),
        .ACC_W    (ACC_W),
        .DELTA_W  (DELTA_W)
    ) u_axis_x (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .delta     (delta_x),
        .delta_stb (delta_stb),
        .dir       (hdir),
        .pclk      (hclk),
        .busy      (busy_x)
    );

    trackball_quad_axis #(
        .STEP_DIV (STEP_DIV),
        .ACC_W    (ACC_W),
        .DELTA_W  (DELTA_W)
    ) u_axis_y (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .delta     (delta_y),
        .delta_stb (delta_stb),
        .dir       (vdir),
        .pclk      (vclk),
        .busy      (busy_y)
    );

    assign busy = busy_x | busy_y;

endmodule

// File: tb/tb_trackball_quad_emulator.sv
// Bench for trackball_quad_emulator: a time-based pulse-train model checked
// every cycle, plus directed scenarios with hand-computed expectations.
`timescale 1ns/1ps

module tb_trackball_quad_emulator;

    localparam int STEP    = 4;
    localparam int ACC_W   = 6;
    localparam int DELTA_W = 9;
    localparam int SAT     = 31;

    logic               clk = 1'b0;
    logic               reset;
    logic               enable;
    logic [DELTA_W-1:0] delta_x;
    logic [DELTA_W-1:0] delta_y;
    logic               delta_stb;
    logic               hdir, hclk, vdir, vclk, busy;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    trackball_quad_emulator #(
        .STEP_DIV (STEP),
        .ACC_W    (ACC_W),
        .DELTA_W  (DELTA_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .delta_x   (delta_x),
        .delta_y   (delta_y),
        .delta_stb (delta_stb),
        .hdir      (hdir),
        .hclk      (hclk),
        .vdir      (vdir),
        .vclk      (vclk),
        .busy      (busy)
    );

    always #50 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: each axis is either idle or in a run that started 'el' cycles ago
    // at the beginning of a setup phase; phase = el / STEP (0 setup, odd high,
    // even low), and pend is plain saturating integer arithmetic.
    int m_pend[2];
    bit m_dir[2];
    bit m_act[2];
    int m_el[2];
    bit m_busy;

    function automatic int sat(input int v);
        if (v > SAT)  return SAT;
        if (v < -SAT) return -SAT;
        return v;
    endfunction

    always @(posedge clk) begin
        int d, old, step, ph;
        cyc++;
        if (reset) begin
            for (int a = 0; a < 2; a++) begin
                m_pend[a] = 0; m_dir[a] = 0; m_act[a] = 0; m_el[a] = 0;
            end
            m_busy = 0;
        end else begin
            for (int a = 0; a < 2; a++) begin
                d    = (a == 0) ? int'($signed(delta_x)) : int'($signed(delta_y));
                old  = m_pend[a];
                step = 0;
                if (!enable) begin
                    m_pend[a] = 0; m_act[a] = 0; m_el[a] = 0;
                end else begin
                    if (!m_act[a]) begin
                        if (old != 0) begin
                            m_act[a] = 1; m_el[a] = 0; m_dir[a] = (old > 0);
                        end
                    end else if (m_el[a] % STEP != STEP - 1) begin
                        m_el[a]++;
                    end else begin
                        ph = m_el[a] / STEP;
                        if (ph == 0) begin
                            step = m_dir[a] ? 1 : -1; m_el[a]++;
                        end else if (ph % 2 == 1) begin
                            m_el[a]++;
                        end else if (old == 0) begin
                            m_act[a] = 0; m_el[a] = 0;
                        end else if ((old > 0) == m_dir[a]) begin
                            step = m_dir[a] ? 1 : -1; m_el[a]++;
                        end else begin
                            m_el[a] = 0; m_dir[a] = (old > 0);
                        end
                    end
                    m_pend[a] = sat(old + (delta_stb ? d : 0) - step);
                end
            end
            m_busy = m_act[0] || m_act[1] || (m_pend[0] != 0) || (m_pend[1] != 0);
        end
    end

    // Observation counters fed from the DUT outputs
    int hrise, vrise, hpos, hneg, vpos, vneg, bad_w, dir_glitch, bfall;
    int hw, vw;
    int hr_q[$];
    int vr_q[$];
    logic ph_q = 1'b0, pv_q = 1'b0, phd_q = 1'b0, pvd_q = 1'b0, pb_q = 1'b0;

    task automatic clr_mon();
        hrise = 0; vrise = 0; hpos = 0; hneg = 0; vpos = 0; vneg = 0;
        bad_w = 0; dir_glitch = 0; bfall = -1; hw = 0; vw = 0;
        hr_q.delete(); vr_q.delete();
    endtask

    // Compare process: one packed comparison per cycle, then bookkeeping
    always begin
        logic [4:0] exp_v;
        @(posedge clk);
        #1;
        exp_v = {m_dir[0], m_act[0] && ((m_el[0] / STEP) % 2 == 1),
                 m_dir[1], m_act[1] && ((m_el[1] / STEP) % 2 == 1), m_busy};
        check("outputs{hdir,hclk,vdir,vclk,busy}", int'({hdir, hclk, vdir, vclk, busy}), int'(exp_v));

        if (hclk && !ph_q) begin
            hrise++; hr_q.push_back(cyc); hw = 0;
            if (hdir) hpos++; else hneg++;
        end
        if (vclk && !pv_q) begin
            vrise++; vr_q.push_back(cyc); vw = 0;
            if (vdir) vpos++; else vneg++;
        end
        if (hclk) hw++;
        if (vclk) vw++;
        if (!hclk && ph_q && hw != STEP) bad_w++;
        if (!vclk && pv_q && vw != STEP) bad_w++;
        if (hclk && ph_q && hdir != phd_q) dir_glitch++;
        if (vclk && pv_q && vdir != pvd_q) dir_glitch++;
        if (!busy && pb_q) bfall = cyc;
        ph_q = hclk; pv_q = vclk; phd_q = hdir; pvd_q = vdir; pb_q = busy;
    end

    task automatic strobe(input int dx, input int dy);
        delta_x   = DELTA_W'(dx);
        delta_y   = DELTA_W'(dy);
        delta_stb = 1'b1;
        @(negedge clk);
        delta_stb = 1'b0;
        delta_x   = '0;
        delta_y   = '0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while ((busy !== 1'b0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, int'(busy), 0);
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_hrise(input string name, input int target, input int budget);
        int n = 0;
        while (hrise < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, hrise, target);
    endtask

    initial begin
        int e0;
        clr_mon();
        reset = 1'b1; enable = 1'b1; delta_stb = 1'b1;
        delta_x = DELTA_W'(5); delta_y = '0;

        // Reset held 3 cycles with a strobe present
        repeat (3) @(negedge clk);
        reset = 1'b0; delta_stb = 1'b0; delta_x = '0;
        repeat (20) @(negedge clk);
        check("reset_busy", int'(busy), 0);
        check("reset_hdir", int'(hdir), 0);
        check("reset_no_pulses", hrise + vrise, 0);

        // Single move +3
        clr_mon();
        e0 = cyc + 1;
        strobe(3, 0);
        check("single_hdir_E0", int'(hdir), 0);
        @(negedge clk);
        check("single_hdir_E0p1", int'(hdir), 1);
        wait_idle("single_idle", 100);
        check("single_pulses", hrise, 3);
        check("single_first_rise", (hr_q.size() > 0) ? hr_q[0] - e0 : -1, 5);
        check("single_period1", (hr_q.size() > 2) ? hr_q[1] - hr_q[0] : -1, 8);
        check("single_period2", (hr_q.size() > 2) ? hr_q[2] - hr_q[1] : -1, 8);
        check("single_width", bad_w, 0);
        check("single_busy_fall", bfall - e0, 29);
        check("single_vclk_quiet", vrise, 0);

        // Concurrent +2 on X, -2 on Y
        clr_mon();
        e0 = cyc + 1;
        strobe(2, -2);
        wait_idle("concurrent_idle", 100);
        check("concurrent_hpos", hpos, 2);
        check("concurrent_hneg", hneg, 0);
        check("concurrent_vneg", vneg, 2);
        check("concurrent_vpos", vpos, 0);
        check("concurrent_first_rise", (hr_q.size() > 0) ? hr_q[0] - e0 : -1, 5);
        check("concurrent_sync", (hr_q.size() > 0 && vr_q.size() > 0) ? hr_q[0] - vr_q[0] : -1, 0);

        // Reversal: +4, then -6 during the second HIGH
        clr_mon();
        strobe(4, 0);
        wait_hrise("reversal_reach_2nd", 2, 100);
        strobe(-6, 0);
        wait_idle("reversal_idle", 200);
        check("reversal_hpos", hpos, 2);
        check("reversal_hneg", hneg, 4);
        check("reversal_setup_gap", (hr_q.size() > 2) ? hr_q[2] - hr_q[1] : -1, 12);
        check("reversal_dir_stable", dir_glitch, 0);
        check("reversal_final_hdir", int'(hdir), 0);

        // Saturation: four back-to-back +255 strobes on Y, then -255
        clr_mon();
        delta_y = DELTA_W'(255); delta_stb = 1'b1;
        repeat (4) @(negedge clk);
        delta_stb = 1'b0; delta_y = '0;
        check("model_pend_sat_pos", m_pend[1], SAT);
        wait_idle("sat_pos_idle", 600);
        check("sat_pos_pulses", vpos, SAT);
        check("sat_pos_neg_pulses", vneg, 0);
        clr_mon();
        delta_y = DELTA_W'(-255); delta_stb = 1'b1;
        repeat (4) @(negedge clk);
        delta_stb = 1'b0; delta_y = '0;
        check("model_pend_sat_neg", m_pend[1], -SAT);
        wait_idle("sat_neg_idle", 600);
        check("sat_neg_pulses", vneg, SAT);
        check("sat_neg_pos_pulses", vpos, 0);
        check("sat_width", bad_w, 0);

        // Flush: +10, drop enable during the second HIGH, strobe while disabled
        clr_mon();
        strobe(10, 0);
        wait_hrise("flush_reach_2nd", 2, 100);
        enable = 1'b0;
        @(negedge clk);
        check("flush_hclk_low", int'(hclk), 0);
        check("flush_busy_low", int'(busy), 0);
        strobe(5, 5);
        enable = 1'b1;
        repeat (40) @(negedge clk);
        check("flush_no_more_pulses", hrise + vrise, 2);
        check("flush_busy_stays_low", int'(busy), 0);
        check("flush_hdir_held", int'(hdir), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/trackball_quad_emulator.md
Name: trackball_quad_emulator

Overview:
- Converts signed relative motion deltas (MiSTer mouse/analog) into per-axis direction + clock pulse trains for the LETA trackball counter inputs.
- This block drives the lines LETA samples: horizontal dir/clock and vertical dir/clock.
- Sits between the HPS input path and the LETA instance in the game top level.
- Its outputs are muxed with the physical trackball lines from USER_IN.

Parameters:
- STEP_DIV, 64: clk cycles per pulse phase (setup, high, low); legal range 2..1023.
- ACC_W, 12: width of each signed pending-count accumulator.
- DELTA_W, 9: width of the signed input deltas.

Ports:
- clk  in  1  system clock (10 MHz); the only clock.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  1 = emulation active; 0 = flush and idle.
- delta_x  in  DELTA_W  signed X motion, two's complement.
- delta_y  in  DELTA_W  signed Y motion, two's complement.
- delta_stb  in  1  one-cycle pulse; delta_x/delta_y are valid in this cycle.
- hdir  out  1  horizontal direction (1 = positive).
- hclk  out  1  horizontal count clock.
- vdir  out  1  vertical direction (1 = positive).
- vclk  out  1  vertical count clock.
- busy  out  1  either axis not IDLE or either accumulator nonzero.

Behaviour:
- Reset (sync, reset=1 at a rising edge):
  - pend_x = pend_y = 0; both FSMs IDLE; phase counters 0.
  - hdir = vdir = hclk = vclk = 0; busy = 0.
  - Reset mid-pulse forces the clock low on that same edge.
- Both axes are identical and independent. The rules below are per axis (pend, dir, pclk, FSM).
- Accumulation:
  - At an edge where delta_stb=1 and enable=1: pend_next = sat(pend + sext(delta) - step).
  - step = +1 if a count is consumed this edge with dir=1, -1 if consumed with dir=0, else 0.
  - Saturate to [-(2^(ACC_W-1)-1), +(2^(ACC_W-1)-1)]. The most negative code is never produced.
  - A delta of 0 is a no-op, apart from any concurrent step.
- FSM states (pclk = 1 only in HIGH):
  - IDLE:
    - If pend != 0, go to SETUP.
    - On this transition dir <= (pend > 0); the phase counter is cleared.
  - SETUP:
    - pclk = 0; count STEP_DIV cycles.
    - Then go to HIGH; a count is consumed on this transition (pend moves one toward zero).
  - HIGH:
    - pclk = 1 for STEP_DIV cycles, then go to LOW.
  - LOW: pclk = 0 for STEP_DIV cycles, then:
    - pend == 0: go to IDLE.
    - sign(pend) matches dir: go to HIGH and consume a count.
    - sign(pend) opposes dir: go to SETUP with dir <= (pend > 0).
- Direction rule: dir changes only on entry to SETUP. It is therefore stable for at least STEP_DIV cycles before each pclk rising edge and during HIGH.
- Latency:
  - delta_stb sampled at edge E0 updates pend at E0.
  - FSM leaves IDLE at E0+1.
  - pclk rises at E0+1+STEP_DIV.
  - A continuous run has pulse period 2*STEP_DIV.
- Pulse count rule: exactly |sum of deltas| rising edges, absent saturation and absent enable drop.
- Reversal while pulses are pending (e.g. pend goes +3 → -2 during HIGH):
  - No further positive pulses are issued.
  - After LOW the FSM goes to SETUP with dir=0, then issues 2 pulses.
  - Counts already consumed are not refunded.
- enable=0 at an edge:
  - pend cleared; delta_stb ignored.
  - FSM goes to IDLE; pclk = 0 on that edge.
  - dir holds its last value.
- busy is registered and follows the state/pend values of the same edge.

Test Plan:
- Reset: STEP_DIV=4, hold reset 3 cycles with delta_stb=1, delta_x=+5 → all outputs 0, no pulses, busy=0 after release.
- Single move: delta_x=+3 one strobe → hdir=1 at E0+1, hclk first rise at E0+5, exactly 3 high pulses each 4 cycles, period 8, busy low after final LOW; vclk never toggles.
- Negative Y with concurrent X: delta_x=+2, delta_y=-2 same strobe → 2 hclk pulses with hdir=1 and 2 vclk pulses with vdir=0, simultaneous and independent.
- Reversal: delta_x=+4, then delta_x=-6 during the 2nd HIGH → 2 positive pulses total, SETUP of 4 cycles with hdir=0, then 4 negative pulses; hdir never changes while hclk=1.
- Saturation: ACC_W=6, four strobes of delta_y=+255 → pend_y clamps at +31, exactly 31 vclk pulses; repeat with -255 → 31 pulses with vdir=0.
- Flush: delta_x=+10, deassert enable during HIGH → hclk low on that edge, no further pulses, busy=0 next cycle; strobe while enable=0 is ignored.
